// File: rtl/stage_me_dmem.sv
// Memory stage: word-addressed data RAM with configurable wait cycles, stall generation,
// and the ME->WB pipeline register.
module stage_me_dmem #(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset_0,
    input  logic [31:0] ans_me,
    input  logic [31:0] b_me,
    input  logic [4:0]  rw_me,
    input  logic        wreg_me,
    input  logic        m2reg_me,
    input  logic        wmem_me,
    output logic        stall_me,
    output logic [31:0] ans_wb,
    output logic [31:0] mo_wb,
    output logic [4:0]  rw_wb,
    output logic        wreg_wb,
    output logic        m2reg_wb
);

    localparam logic       S_IDLE = 1'b0;
    localparam logic       S_BUSY = 1'b1;
    localparam logic [3:0] WAIT_C = 4'(WAIT_CYCLES);

    logic [31:0] mem [0:(1 << ADDR_BITS) - 1];

    logic                 state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [31:0]          ans_wb_q, ans_wb_d;
    logic [31:0]          mo_wb_q, mo_wb_d;
    logic [4:0]           rw_wb_q, rw_wb_d;
    logic                 wreg_wb_q, wreg_wb_d;
    logic                 m2reg_wb_q, m2reg_wb_d;

    logic                 access;
    logic                 stall_raw;
    logic                 complete;
    logic [ADDR_BITS-1:0] idx;

    assign idx    = ans_me[ADDR_BITS+1:2];
    assign access = m2reg_me | wmem_me;

    always_comb begin
        stall_raw = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        if (state_q == S_IDLE) begin
            if (access && (WAIT_C != 4'd0)) begin
                stall_raw = 1'b1;
                cnt_d     = 4'd1;
                state_d   = S_BUSY;
            end
        end else begin
            if (cnt_q < WAIT_C) begin
                stall_raw = 1'b1;
                cnt_d     = cnt_q + 4'd1;
            end else begin
                cnt_d   = 4'd0;
                state_d = S_IDLE;
            end
        end
    end

    // Reset gates both the stall and the write so an aborted access leaves RAM untouched.
    assign stall_me = reset_0 & stall_raw;
    assign complete = reset_0 & access & ~stall_raw;

    always_comb begin
        ans_wb_d   = ans_wb_q;
        mo_wb_d    = mo_wb_q;
        rw_wb_d    = rw_wb_q;
        wreg_wb_d  = 1'b0;
        m2reg_wb_d = 1'b0;
        if (!stall_raw) begin
            ans_wb_d   = ans_me;
            mo_wb_d    = mem[idx];
            rw_wb_d    = rw_me;
            wreg_wb_d  = wreg_me;
            m2reg_wb_d = m2reg_me;
        end
    end

    always_ff @(posedge clock) begin
        if (complete && wmem_me)
            mem[idx] <= b_me;
    end

    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            ans_wb_q   <= 32'd0;
            mo_wb_q    <= 32'd0;
            rw_wb_q    <= 5'd0;
            wreg_wb_q  <= 1'b0;
            m2reg_wb_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ans_wb_q   <= ans_wb_d;
            mo_wb_q    <= mo_wb_d;
            rw_wb_q    <= rw_wb_d;
            wreg_wb_q  <= wreg_wb_d;
            m2reg_wb_q <= m2reg_wb_d;
        end
    end

    assign ans_wb   = ans_wb_q;
    assign mo_wb    = mo_wb_q;
    assign rw_wb    = rw_wb_q;
    assign wreg_wb  = wreg_wb_q;
    assign m2reg_wb = m2reg_wb_q;

endmodule

// File: tb/tb_stage_me_dmem.sv
// Directed bench for stage_me_dmem: a 2-wait-cycle instance and a single-cycle instance.
module tb_stage_me_dmem;

    logic clk;
    logic reset_0;

    logic [31:0] a_ans, a_b;
    logic [4:0]  a_rw;
    logic        a_wreg, a_m2reg, a_wmem;
    logic        a_stall;
    logic [31:0] a_ans_wb, a_mo_wb;
    logic [4:0]  a_rw_wb;
    logic        a_wreg_wb, a_m2reg_wb;

    logic [31:0] z_ans, z_b;
    logic [4:0]  z_rw;
    logic        z_wreg, z_m2reg, z_wmem;
    logic        z_stall;
    logic [31:0] z_ans_wb, z_mo_wb;
    logic [4:0]  z_rw_wb;
    logic        z_wreg_wb, z_m2reg_wb;

    int checks = 0;
    int errors = 0;

    stage_me_dmem #(.ADDR_BITS(8), .WAIT_CYCLES(2)) dut_w2 (
        .clock(clk), .reset_0(reset_0),
        .ans_me(a_ans), .b_me(a_b), .rw_me(a_rw),
        .wreg_me(a_wreg), .m2reg_me(a_m2reg), .wmem_me(a_wmem),
        .stall_me(a_stall), .ans_wb(a_ans_wb), .mo_wb(a_mo_wb), .rw_wb(a_rw_wb),
        .wreg_wb(a_wreg_wb), .m2reg_wb(a_m2reg_wb)
    );

    stage_me_dmem #(.ADDR_BITS(8), .WAIT_CYCLES(0)) dut_w0 (
        .clock(clk), .reset_0(reset_0),
        .ans_me(z_ans), .b_me(z_b), .rw_me(z_rw),
        .wreg_me(z_wreg), .m2reg_me(z_m2reg), .wmem_me(z_wmem),
        .stall_me(z_stall), .ans_wb(z_ans_wb), .mo_wb(z_mo_wb), .rw_wb(z_rw_wb),
        .wreg_wb(z_wreg_wb), .m2reg_wb(z_m2reg_wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [31:0] ans, input logic [31:0] b, input logic [4:0] rw,
                           input logic wreg, input logic m2reg, input logic wmem);
        a_ans = ans; a_b = b; a_rw = rw; a_wreg = wreg; a_m2reg = m2reg; a_wmem = wmem;
    endtask

    task automatic drive_z(input logic [31:0] ans, input logic [31:0] b, input logic [4:0] rw,
                           input logic wreg, input logic m2reg, input logic wmem);
        z_ans = ans; z_b = b; z_rw = rw; z_wreg = wreg; z_m2reg = m2reg; z_wmem = wmem;
    endtask

    initial begin
        reset_0 = 1'b0;
        drive_a(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        drive_z(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_ans_wb",   a_ans_wb,   32'd0);
        chk("rst_mo_wb",    a_mo_wb,    32'd0);
        chk("rst_rw_wb",    a_rw_wb,    32'd0);
        chk("rst_wreg_wb",  a_wreg_wb,  32'd0);
        chk("rst_m2reg_wb", a_m2reg_wb, 32'd0);
        chk("rst_stall",    a_stall,    32'd0);
        reset_0 = 1'b1;

        // sw 0x10 <- DEADBEEF, stall pattern 1,1,0 with bubbles while stalled
        drive_a(32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("sw_stall_c0", a_stall, 32'd1);
        tick();
        chk("sw_stall_c1", a_stall, 32'd1);
        chk("sw_bub_wreg_c1",  a_wreg_wb,  32'd0);
        chk("sw_bub_m2reg_c1", a_m2reg_wb, 32'd0);
        tick();
        chk("sw_stall_c2", a_stall, 32'd0);
        chk("sw_bub_wreg_c2",  a_wreg_wb,  32'd0);
        tick();
        chk("sw_done_ans_wb", a_ans_wb, 32'h10);
        chk("sw_done_rw_wb",  a_rw_wb,  32'd0);

        // lw 0x10 -> r5
        drive_a(32'h10, 32'd0, 5'd5, 1'b1, 1'b1, 1'b0);
        #1;
        chk("lw_stall_c0", a_stall, 32'd1);
        tick();
        chk("lw_stall_c1", a_stall, 32'd1);
        chk("lw_bub_wreg",  a_wreg_wb,  32'd0);
        chk("lw_bub_m2reg", a_m2reg_wb, 32'd0);
        chk("lw_bub_rw_hold", a_rw_wb, 32'd0);
        tick();
        chk("lw_stall_c2", a_stall, 32'd0);
        tick();
        chk("lw_wreg_wb",  a_wreg_wb,  32'd1);
        chk("lw_m2reg_wb", a_m2reg_wb, 32'd1);
        chk("lw_rw_wb",    a_rw_wb,    32'd5);
        chk("lw_mo_wb",    a_mo_wb,    32'hDEADBEEF);

        // ALU pass-through
        drive_a(32'h1234, 32'd0, 5'd7, 1'b1, 1'b0, 1'b0);
        #1;
        chk("alu_stall", a_stall, 32'd0);
        tick();
        chk("alu_ans_wb",   a_ans_wb,   32'h1234);
        chk("alu_rw_wb",    a_rw_wb,    32'd7);
        chk("alu_wreg_wb",  a_wreg_wb,  32'd1);
        chk("alu_m2reg_wb", a_m2reg_wb, 32'd0);

        // Address wrap: 0x400 aliases word 0, low bits ignored
        drive_a(32'h400, 32'hCAFEF00D, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        drive_a(32'h3, 32'd0, 5'd3, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        chk("wrap_mo_wb",  a_mo_wb,  32'hCAFEF00D);
        chk("wrap_ans_wb", a_ans_wb, 32'h3);
        chk("wrap_rw_wb",  a_rw_wb,  32'd3);

        // Reset in the middle of a store must abort it
        drive_a(32'h10, 32'h11111111, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("abort_busy_stall", a_stall, 32'd1);
        reset_0 = 1'b0;
        #1;
        chk("abort_stall",    a_stall,    32'd0);
        chk("abort_ans_wb",   a_ans_wb,   32'd0);
        chk("abort_mo_wb",    a_mo_wb,    32'd0);
        chk("abort_wreg_wb",  a_wreg_wb,  32'd0);
        chk("abort_m2reg_wb", a_m2reg_wb, 32'd0);
        tick();
        drive_a(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        reset_0 = 1'b1;
        drive_a(32'h10, 32'd0, 5'd4, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        chk("abort_ram_kept", a_mo_wb, 32'hDEADBEEF);
        chk("abort_lw_rw",    a_rw_wb, 32'd4);

        // Single-cycle memory: back-to-back sw/lw, then the illegal both-set encoding
        drive_z(32'h20, 32'hA5A5A5A5, 5'd0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("w0_sw_stall", z_stall, 32'd0);
        tick();
        drive_z(32'h20, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0);
        #1;
        chk("w0_lw_stall", z_stall, 32'd0);
        tick();
        chk("w0_lw_mo_wb",   z_mo_wb,   32'hA5A5A5A5);
        chk("w0_lw_rw_wb",   z_rw_wb,   32'd9);
        chk("w0_lw_wreg_wb", z_wreg_wb, 32'd1);
        drive_z(32'h20, 32'h5A5A5A5A, 5'd2, 1'b1, 1'b1, 1'b1);
        #1;
        chk("w0_both_stall", z_stall, 32'd0);
        tick();
        chk("w0_both_mo_old", z_mo_wb, 32'hA5A5A5A5);
        drive_z(32'h20, 32'd0, 5'd2, 1'b1, 1'b1, 1'b0);
        tick();
        chk("w0_both_mo_new", z_mo_wb, 32'h5A5A5A5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
